// File: rtl/delay_line_arbiter.sv
// -----------------------------------------------------------------------------
// delay_line_arbiter
//
// Shares one external fixed-latency 1-bit delay datapath between two
// requesters (A and B). Each cycle at most one requester is granted with
// round-robin priority; its bit is driven onto line_in. A tag shift register
// follows every in-flight bit so the matching line_out bit, LATENCY cycles
// later, is returned as a registered response to the requester that issued it.
// A drain handshake stops new grants and reports when the datapath is empty.
//
// Parameters:
//   LATENCY  cycles from line_in to the matching line_out (1..15)
//   CNT_W    width of in_flight; 2**CNT_W must exceed LATENCY
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   a_req/b_req  requester wants to issue a bit
//   a_data/b_data requester bit
//   a_gnt/b_gnt  combinational grant for the current cycle
//   line_in      bit to the delay datapath (0 when nothing is granted)
//   line_out     bit from the delay datapath
//   a_rsp_valid/b_rsp_valid  registered one-cycle response strobe
//   a_rsp_data/b_rsp_data    registered response bit (holds between strobes)
//   drain        stop granting and empty the datapath
//   drain_done   level: datapath empty and grants halted
//   in_flight    number of bits currently inside the datapath
// -----------------------------------------------------------------------------
module delay_line_arbiter #(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_req,
    input  logic             a_data,
    output logic             a_gnt,
    input  logic             b_req,
    input  logic             b_data,
    output logic             b_gnt,
    output logic             line_in,
    input  logic             line_out,
    output logic             a_rsp_valid,
    output logic             a_rsp_data,
    output logic             b_rsp_valid,
    output logic             b_rsp_data,
    input  logic             drain,
    output logic             drain_done,
    output logic [CNT_W-1:0] in_flight
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_last_b;       // 1: B was granted most recently
    logic [LATENCY-1:0] r_tag_vld;      // bit k = stage k+1
    logic [LATENCY-1:0] r_tag_own;      // 1: bit belongs to B
    logic [LATENCY-1:0] w_tag_vld_nxt;
    logic [LATENCY-1:0] w_tag_own_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_a_rsp_valid;
    logic               r_a_rsp_data;
    logic               r_b_rsp_valid;
    logic               r_b_rsp_data;
    logic               w_gen;
    logic               w_a_gnt;
    logic               w_b_gnt;
    logic               w_gnt;
    logic               w_retire;
    logic               w_ret_own_b;
    logic               w_a_ret;
    logic               w_b_ret;
    logic               w_empty_nxt;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    assign w_gen = (r_state == ST_RUN) && !drain;

    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (w_gen) begin
            if (a_req && b_req) begin
                // Contention: the side not granted most recently wins.
                w_a_gnt = r_last_b;
                w_b_gnt = !r_last_b;
            end else begin
                w_a_gnt = a_req;
                w_b_gnt = b_req;
            end
        end
    end

    assign w_gnt   = w_a_gnt | w_b_gnt;
    assign a_gnt   = w_a_gnt;
    assign b_gnt   = w_b_gnt;
    assign line_in = (w_a_gnt & a_data) | (w_b_gnt & b_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_b <= 1'b1;
        end else if (w_gnt) begin
            r_last_b <= w_b_gnt;
        end
    end

    // -------------------------------------------------------------------------
    // Ownership tags: one {valid, owner} entry per datapath stage
    // -------------------------------------------------------------------------
    always_comb begin
        w_tag_vld_nxt    = r_tag_vld;
        w_tag_own_nxt    = r_tag_own;
        w_tag_vld_nxt[0] = w_gnt;
        w_tag_own_nxt[0] = w_b_gnt;
        for (int k = 1; k < int'(LATENCY); k++) begin
            w_tag_vld_nxt[k] = r_tag_vld[k-1];
            w_tag_own_nxt[k] = r_tag_own[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_vld <= '0;
            r_tag_own <= '0;
        end else begin
            r_tag_vld <= w_tag_vld_nxt;
            r_tag_own <= w_tag_own_nxt;
        end
    end

    // The last stage lines up with the bit currently on line_out.
    assign w_retire    = r_tag_vld[LATENCY-1];
    assign w_ret_own_b = r_tag_own[LATENCY-1];
    assign w_a_ret     = w_retire & !w_ret_own_b;
    assign w_b_ret     = w_retire & w_ret_own_b;

    // -------------------------------------------------------------------------
    // In-flight counter
    // -------------------------------------------------------------------------
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_gnt && !w_retire) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (!w_gnt && w_retire) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign in_flight   = r_cnt;
    // Looking at the post-edge count lets HALT be entered on the same edge the
    // final bit retires, so an already-empty datapath halts one cycle after
    // drain rises.
    assign w_empty_nxt = (w_cnt_nxt == '0);

    // -------------------------------------------------------------------------
    // Drain state machine
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (drain) begin
                    w_state_nxt = w_empty_nxt ? ST_HALT : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!drain) begin
                    w_state_nxt = ST_RUN;
                end else if (w_empty_nxt) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!drain) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign drain_done = (r_state == ST_HALT);

    // -------------------------------------------------------------------------
    // Response capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_rsp_valid <= 1'b0;
            r_a_rsp_data  <= 1'b0;
            r_b_rsp_valid <= 1'b0;
            r_b_rsp_data  <= 1'b0;
        end else begin
            r_a_rsp_valid <= w_a_ret;
            r_b_rsp_valid <= w_b_ret;
            if (w_a_ret) begin
                r_a_rsp_data <= line_out;
            end
            if (w_b_ret) begin
                r_b_rsp_data <= line_out;
            end
        end
    end

    assign a_rsp_valid = r_a_rsp_valid;
    assign a_rsp_data  = r_a_rsp_data;
    assign b_rsp_valid = r_b_rsp_valid;
    assign b_rsp_data  = r_b_rsp_data;

endmodule
